// File: rtl/ddr_rx_sequencer.sv
// rtl/ddr_rx_sequencer.sv - HDR-DDR receive sequencer: preamble/byte/parity/token/CRC mode walk.
// Optional wait-for-mode_done watchdog built only when RX_SEQ_TIMEOUT_EN is defined.
module ddr_rx_sequencer #(
  parameter logic [7:0]  MAX_WORDS   = 8'd255,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4095
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_engine_start,
  input  logic       i_engine_abort,
  input  logic       i_rx_mode_done,
  input  logic       i_rx_pre,
  input  logic       i_rx_error,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_byte_valid,
  output logic       o_rx_en,
  output logic [3:0] o_rx_mode,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic [7:0] o_word_cnt,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [2:0] o_err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_BYTE_HI, S_BYTE_LO, S_PAR, S_TOKEN, S_CRC, S_ERR
  } state_t;

  localparam logic [3:0] M_PRE  = 4'd0;
  localparam logic [3:0] M_BYTE = 4'd3;
  localparam logic [3:0] M_TOK  = 4'd4;
  localparam logic [3:0] M_PAR  = 4'd5;
  localparam logic [3:0] M_CRC  = 4'd6;
  localparam logic [3:0] M_ERR  = 4'd7;

  state_t state;
  logic   byte_window;
  logic   timeout_hit;

  assign byte_window = (state == S_BYTE_HI) || (state == S_BYTE_LO) || (state == S_PAR);

`ifdef RX_SEQ_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign timeout_hit = (state != S_IDLE) && (state != S_ERR) &&
                       (tmo_cnt == TIMEOUT_CYC - 16'd1);

  // Every state change is caused by mode_done, a timeout, abort or start, so
  // clearing on those (and in IDLE/ERR) covers every state entry.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      tmo_cnt <= '0;
    end else if (i_rx_mode_done || timeout_hit || i_engine_abort ||
                 (state == S_IDLE) || (state == S_ERR)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state        <= S_IDLE;
      o_rx_en      <= 1'b0;
      o_rx_mode    <= M_PRE;
      o_data       <= 8'd0;
      o_data_valid <= 1'b0;
      o_word_cnt   <= 8'd0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_err_code   <= 3'd0;
    end else begin
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_data_valid <= i_rx_byte_valid && byte_window;
      if (i_rx_byte_valid && byte_window) begin
        o_data <= i_rx_byte;
      end

      if (state == S_IDLE) begin
        // busy covers the done-pulse cycle, so a start there is still ignored
        if (o_done) begin
          o_busy <= 1'b0;
        end
        if (i_engine_start && !i_engine_abort && !o_busy) begin
          state      <= S_PRE;
          o_rx_en    <= 1'b1;
          o_rx_mode  <= M_PRE;
          o_word_cnt <= 8'd0;
          o_err_code <= 3'd0;
          o_busy     <= 1'b1;
        end
      end else if (i_engine_abort) begin
        state     <= S_IDLE;
        o_rx_en   <= 1'b0;
        o_rx_mode <= M_PRE;
        o_busy    <= 1'b0;
      end else if (timeout_hit && !i_rx_mode_done) begin
        state      <= S_ERR;
        o_rx_mode  <= M_ERR;
        o_err_code <= 3'd5;
      end else if (i_rx_mode_done) begin
        case (state)
          S_PRE: begin
            if (!i_rx_pre) begin
              state     <= S_TOKEN;
              o_rx_mode <= M_TOK;
            end else if (o_word_cnt < MAX_WORDS) begin
              state     <= S_BYTE_HI;
              o_rx_mode <= M_BYTE;
            end else begin
              state      <= S_ERR;
              o_rx_mode  <= M_ERR;
              o_err_code <= 3'd4;
            end
          end
          S_BYTE_HI: begin
            state     <= S_BYTE_LO;
            o_rx_mode <= M_BYTE;
          end
          S_BYTE_LO: begin
            state     <= S_PAR;
            o_rx_mode <= M_PAR;
          end
          S_PAR: begin
            if (i_rx_error) begin
              state      <= S_ERR;
              o_rx_mode  <= M_ERR;
              o_err_code <= 3'd1;
            end else begin
              state     <= S_PRE;
              o_rx_mode <= M_PRE;
              if (o_word_cnt < MAX_WORDS) begin
                o_word_cnt <= o_word_cnt + 8'd1;
              end
            end
          end
          S_TOKEN: begin
            if (i_rx_error) begin
              state      <= S_ERR;
              o_rx_mode  <= M_ERR;
              o_err_code <= 3'd2;
            end else begin
              state     <= S_CRC;
              o_rx_mode <= M_CRC;
            end
          end
          S_CRC: begin
            state     <= S_IDLE;
            o_rx_en   <= 1'b0;
            o_rx_mode <= M_PRE;
            o_done    <= 1'b1;
            if (i_rx_error) begin
              o_error    <= 1'b1;
              o_err_code <= 3'd3;
            end
          end
          S_ERR: begin
            state     <= S_IDLE;
            o_rx_en   <= 1'b0;
            o_rx_mode <= M_PRE;
            o_done    <= 1'b1;
            o_error   <= 1'b1;
          end
          default: begin
            state     <= S_IDLE;
            o_rx_en   <= 1'b0;
            o_rx_mode <= M_PRE;
            o_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_rx_sequencer.sv
// tb/tb_ddr_rx_sequencer.sv - directed bench for ddr_rx_sequencer (MAX_WORDS=2, TIMEOUT_CYC=16).
module tb_ddr_rx_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, mode_done, pre, rx_err;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       rx_en;
  logic [3:0] rx_mode;
  logic [7:0] data;
  logic       data_valid;
  logic [7:0] word_cnt;
  logic       busy, done, error;
  logic [2:0] err_code;

  int tests = 0;
  int fails = 0;
  int dv_cnt = 0;

  ddr_rx_sequencer #(.MAX_WORDS(8'd2), .TIMEOUT_CYC(16'd16)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_engine_start(start), .i_engine_abort(abort),
    .i_rx_mode_done(mode_done), .i_rx_pre(pre), .i_rx_error(rx_err),
    .i_rx_byte(rx_byte), .i_rx_byte_valid(byte_valid),
    .o_rx_en(rx_en), .o_rx_mode(rx_mode), .o_data(data), .o_data_valid(data_valid),
    .o_word_cnt(word_cnt), .o_busy(busy), .o_done(done), .o_error(error),
    .o_err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (data_valid) dv_cnt <= dv_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic md(input logic p, input logic e);
    mode_done = 1'b1; pre = p; rx_err = e;
    tick();
    mode_done = 1'b0; pre = 1'b0; rx_err = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    chk("byte_valid", 16'(data_valid), 16'd1);
    chk("byte_data", 16'(data), 16'(b));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 16'(busy), 16'd1);
    chk("start_mode", 16'(rx_mode), 16'd0);
  endtask

  task automatic do_word(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] cnt);
    md(1'b1, 1'b0); chk("mode_hi", 16'(rx_mode), 16'd3);
    send_byte(hi);
    md(1'b0, 1'b0); chk("mode_lo", 16'(rx_mode), 16'd3);
    send_byte(lo);
    md(1'b0, 1'b0); chk("mode_par", 16'(rx_mode), 16'd5);
    md(1'b0, 1'b0); chk("mode_pre", 16'(rx_mode), 16'd0);
    chk("word_cnt", 16'(word_cnt), 16'(cnt));
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; mode_done = 0; pre = 0; rx_err = 0;
    rx_byte = 8'h00; byte_valid = 0;
    tick(); tick();
    chk("rst_en", 16'(rx_en), 16'd0);
    chk("rst_mode", 16'(rx_mode), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_cnt", 16'(word_cnt), 16'd0);
    chk("rst_code", 16'(err_code), 16'd0);
    rst = 1'b0;
    tick();

    // clean two-word transfer
    dv_cnt = 0;
    do_start();
    chk("start_en", 16'(rx_en), 16'd1);
    rx_byte = 8'hEE; byte_valid = 1'b1; tick(); byte_valid = 1'b0;
    chk("pre_strobe_ignored", 16'(data_valid), 16'd0);
    do_word(8'hA5, 8'h5A, 8'd1);
    do_word(8'h12, 8'h34, 8'd2);
    md(1'b0, 1'b0); chk("mode_tok", 16'(rx_mode), 16'd4);
    md(1'b0, 1'b0); chk("mode_crc", 16'(rx_mode), 16'd6);
    md(1'b0, 1'b0);
    chk("t1_done", 16'(done), 16'd1);
    chk("t1_error", 16'(error), 16'd0);
    chk("t1_cnt", 16'(word_cnt), 16'd2);
    chk("t1_en", 16'(rx_en), 16'd0);
    chk("t1_busy_done_cyc", 16'(busy), 16'd1);
    tick();
    chk("t1_done_clr", 16'(done), 16'd0);
    chk("t1_busy_clr", 16'(busy), 16'd0);
    chk("t1_dv_pulses", 16'(dv_cnt), 16'd4);

    // parity error on the first PAR
    do_start();
    md(1'b1, 1'b0); md(1'b0, 1'b0); md(1'b0, 1'b0);
    chk("t2_mode_par", 16'(rx_mode), 16'd5);
    md(1'b0, 1'b1);
    chk("t2_mode_err", 16'(rx_mode), 16'd7);
    md(1'b0, 1'b0);
    chk("t2_done", 16'(done), 16'd1);
    chk("t2_error", 16'(error), 16'd1);
    chk("t2_code", 16'(err_code), 16'd1);
    chk("t2_cnt", 16'(word_cnt), 16'd0);
    tick();

    // CRC error ends directly in IDLE
    do_start();
    chk("t3_code_clr", 16'(err_code), 16'd0);
    md(1'b0, 1'b0); md(1'b0, 1'b0);
    chk("t3_mode_crc", 16'(rx_mode), 16'd6);
    md(1'b0, 1'b1);
    chk("t3_done", 16'(done), 16'd1);
    chk("t3_error", 16'(error), 16'd1);
    chk("t3_code", 16'(err_code), 16'd3);
    chk("t3_en", 16'(rx_en), 16'd0);
    tick();
    chk("t3_idle_mode", 16'(rx_mode), 16'd0);
    chk("t3_idle_en", 16'(rx_en), 16'd0);

    // overflow on a third word
    do_start();
    do_word(8'h01, 8'h02, 8'd1);
    do_word(8'h03, 8'h04, 8'd2);
    md(1'b1, 1'b0);
    chk("t4_mode_err", 16'(rx_mode), 16'd7);
    chk("t4_code", 16'(err_code), 16'd4);
    chk("t4_cnt", 16'(word_cnt), 16'd2);
    md(1'b0, 1'b0);
    chk("t4_done", 16'(done), 16'd1);
    chk("t4_error", 16'(error), 16'd1);
    tick();

    // abort in BYTE_LO with simultaneous mode_done
    do_start();
    md(1'b1, 1'b0); md(1'b0, 1'b0);
    chk("t5_mode_lo", 16'(rx_mode), 16'd3);
    abort = 1'b1;
    md(1'b0, 1'b0);
    abort = 1'b0;
    chk("t5_en", 16'(rx_en), 16'd0);
    chk("t5_mode", 16'(rx_mode), 16'd0);
    chk("t5_busy", 16'(busy), 16'd0);
    chk("t5_code", 16'(err_code), 16'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t5_no_done", 16'(done), 16'd0);
      tick();
    end
    do_start();
    md(1'b0, 1'b0); md(1'b0, 1'b0); md(1'b0, 1'b0);
    chk("t5_done", 16'(done), 16'd1);
    chk("t5_error", 16'(error), 16'd0);
    chk("t5_cnt", 16'(word_cnt), 16'd0);
    tick();

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t6_busy", 16'(busy), 16'd0);
    chk("t6_en", 16'(rx_en), 16'd0);

    // stall in PRE with no mode_done
    do_start();
`ifdef RX_SEQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    chk("t7_still_pre", 16'(rx_mode), 16'd0);
    tick();
    chk("t7_mode_err", 16'(rx_mode), 16'd7);
    chk("t7_code", 16'(err_code), 16'd5);
    md(1'b0, 1'b0);
    chk("t7_done", 16'(done), 16'd1);
    chk("t7_error", 16'(error), 16'd1);
`else
    for (int i = 0; i < 1000; i++) tick();
    chk("t7_still_pre", 16'(rx_mode), 16'd0);
    chk("t7_still_en", 16'(rx_en), 16'd1);
    chk("t7_still_busy", 16'(busy), 16'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t7_abort_en", 16'(rx_en), 16'd0);
`endif

    // asynchronous reset mid-transfer
    tick();
    do_start();
    md(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t8_async_en", 16'(rx_en), 16'd0);
    chk("t8_async_mode", 16'(rx_mode), 16'd0);
    tick();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
